// File: rtl/spm_seq_ctrl.sv
// spm_seq_ctrl: sequencing front/back end for the serial-parallel multiplier CSA array.
//
// Accepts an operand pair (in_x multiplicand, in_y multiplier) over a valid/ready handshake.
// It clears the array for one cycle, holds x on spm_x and streams y LSB-first on spm_y,
// extended to 2N bits. It collects 2N serial product bits from spm_p and returns the 2N-bit
// product over a second valid/ready handshake.
//
// Ports:
//   clk, rst (sync, active-low)
//   in_valid / in_ready / in_x / in_y    operand handshake
//   out_valid / out_ready / out_p        product handshake
//   spm_x, spm_y, spm_clr_n, spm_p       array side
//
// Build option: define SPM_SIGNED_EN for two's-complement operation (y is sign-extended from a
// captured sign register). Otherwise y is zero-extended and the product is unsigned.
//
// Output timing: spm_x, spm_y and spm_clr_n are registered from the next state, so they line
// up with the cycle counter. in_ready and out_valid are registered from the current state,
// so they trail the state register by one cycle.

module spm_seq_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned P_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic [N-1:0]   spm_x,
  output logic           spm_y,
  output logic           spm_clr_n,
  input  logic           spm_p
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(2 * N + P_LAT + 1);
  localparam logic [CW-1:0] LastCnt  = CW'(2 * N + P_LAT - 1);
  localparam logic [CW-1:0] ExtEnd   = CW'(2 * N);
  localparam logic [CW-1:0] CapStart = CW'(P_LAT);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    y_sh_q, y_sh_d;
  logic [PW-1:0]   p_sh_q, p_sh_d;
  logic            in_ready_d, out_valid_d, spm_y_d, spm_clr_n_d;
  logic [PW-1:0]   out_p_d;
  logic [N-1:0]    spm_x_d;
  logic            y_fill;
  logic            accept, out_fire;

`ifdef SPM_SIGNED_EN
  logic sign_q, sign_d;
  assign y_fill = sign_q;
`else
  assign y_fill = 1'b0;
`endif

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_sh_d  = y_sh_q;
    p_sh_d  = p_sh_q;
    spm_y_d = 1'b0;
`ifdef SPM_SIGNED_EN
    sign_d  = sign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d     = in_x;
          y_sh_d  = in_y;
`ifdef SPM_SIGNED_EN
          sign_d  = in_y[N-1];
`endif
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        // Present y bit 0 together with counter value 0.
        state_d = StRun;
        cnt_d   = '0;
        spm_y_d = y_sh_q[0];
        y_sh_d  = {y_fill, y_sh_q[N-1:1]};
      end
      StRun: begin
        if (cnt_q >= CapStart) begin
          p_sh_d = {spm_p, p_sh_q[PW-1:1]};
        end
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Once all N real bits are out, y_sh holds only fill bits, which gives the extension.
          if (cnt_d < ExtEnd) begin
            spm_y_d = y_sh_q[0];
          end
          y_sh_d = {y_fill, y_sh_q[N-1:1]};
        end
      end
      StDone: begin
        if (out_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_q == StIdle) && !accept;
    out_valid_d = (state_q == StDone) && !out_fire;
    out_p_d     = (state_q == StDone) ? p_sh_q : out_p;
    spm_x_d     = (state_d == StRun) ? x_d : spm_x;
    spm_clr_n_d = (state_d != StClear);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      x_q       <= '0;
      y_sh_q    <= '0;
      p_sh_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      spm_x     <= '0;
      spm_y     <= 1'b0;
      spm_clr_n <= 1'b0;
`ifdef SPM_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_sh_q    <= y_sh_d;
      p_sh_q    <= p_sh_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_p     <= out_p_d;
      spm_x     <= spm_x_d;
      spm_y     <= spm_y_d;
      spm_clr_n <= spm_clr_n_d;
`ifdef SPM_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Testbench for spm_seq_ctrl (N=8, P_LAT=1) with a behavioural serial-parallel array model.
// Expected products and accept times are queued when operands are accepted, and they are
// compared when the product handshake occurs.

module tb_spm_seq_ctrl;

  localparam int unsigned N     = 8;
  localparam int unsigned P_LAT = 1;
  localparam int Lat    = 2 * N + P_LAT + 2;
  localparam int Period = Lat + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_p;
  logic [7:0]  spm_x;
  logic        spm_y;
  logic        spm_clr_n;
  logic        spm_p = 1'b0;

  always #5 clk = ~clk;

  spm_seq_ctrl #(.N(N), .P_LAT(P_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_clr_n (spm_clr_n),
    .spm_p     (spm_p)
  );

  // Serial-parallel array: accumulate y_j * x, emit the LSB each cycle (one-cycle latency).
  logic signed [17:0] acc = '0;
  logic signed [17:0] xe, sum;
  always_comb begin
`ifdef SPM_SIGNED_EN
    xe = {{10{spm_x[7]}}, spm_x};
`else
    xe = {10'b0, spm_x};
`endif
    sum = acc + (spm_y ? xe : 18'sd0);
  end
  always @(posedge clk) begin
    if (!spm_clr_n) begin
      acc   <= '0;
      spm_p <= 1'b0;
    end else begin
      spm_p <= sum[0];
      acc   <= sum >>> 1;
    end
  end

  function automatic logic [15:0] exp_prod(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] xw, yw;
`ifdef SPM_SIGNED_EN
    xw = {{8{x[7]}}, x};
    yw = {{8{y[7]}}, y};
`else
    xw = {8'b0, x};
    yw = {8'b0, y};
`endif
    return xw * yw;
  endfunction

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [15:0] exp_q[$];
  int          acc_q[$];

  // Output monitor, sampled on the falling edge.
  logic ov_prev = 1'b0, or_prev = 1'b0;
  int   last_rise = 0;
  bit   b2b = 1'b0, b2b_have = 1'b0;
  int   acc_edge;
  always @(negedge clk) begin
    if (rst) begin
      if (ov_prev && or_prev) check_eq("ov_pulse", {31'b0, out_valid}, 0);
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          check_eq("unexpected_ov", {31'b0, out_valid}, 0);
        end else begin
          acc_edge = acc_q.pop_front();
          check_eq("latency", cyc - acc_edge, Lat);
          if (b2b && b2b_have) check_eq("interval", cyc - last_rise, Period);
          last_rise <= cyc;
          b2b_have  <= b2b;
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check_eq("product", {16'b0, out_p}, {16'b0, exp_q.pop_front()});
      end
    end
    ov_prev <= out_valid;
    or_prev <= out_ready;
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    int n = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", {31'b0, in_ready}, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() > 0) check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 1);
    check_eq({tag, "_out_valid"}, {31'b0, out_valid}, 0);
    check_eq({tag, "_out_p"}, {16'b0, out_p}, 0);
    check_eq({tag, "_spm_x"}, {24'b0, spm_x}, 0);
    check_eq({tag, "_spm_y"}, {31'b0, spm_y}, 0);
    check_eq({tag, "_spm_clr_n"}, {31'b0, spm_clr_n}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx, ry;
    int n;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst0");
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_clr_n", {31'b0, spm_clr_n}, 1);
    check_eq("idle_in_ready", {31'b0, in_ready}, 1);

    // Basic: CLEAR cycle, first RUN cycle, then the product.
    send(8'd3, 8'd5, 16'h000F);
    check_eq("clear_clr_n", {31'b0, spm_clr_n}, 0);
    check_eq("clear_spm_y", {31'b0, spm_y}, 0);
    check_eq("busy_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    check_eq("run_clr_n", {31'b0, spm_clr_n}, 1);
    check_eq("run_spm_x", {24'b0, spm_x}, 8'd3);
    check_eq("run_spm_y0", {31'b0, spm_y}, 1);
    wait_drain();

`ifdef SPM_SIGNED_EN
    send(8'hFE, 8'h03, 16'hFFFA);
    send(8'h80, 8'h80, 16'h4000);
`else
    send(8'hFF, 8'hFF, 16'hFE01);
    send(8'hFE, 8'h03, 16'h02FA);
`endif
    wait_drain();

    // Backpressure: hold the product for 10 cycles while a second operand waits.
    send(8'h21, 8'h13, 16'h0273);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("bp_out_valid", {31'b0, out_valid}, 1);
    in_x = 8'h0B;
    in_y = 8'h0D;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid", {31'b0, out_valid}, 1);
      check_eq("bp_hold_p", {16'b0, out_p}, 16'h0273);
      check_eq("bp_in_ready", {31'b0, in_ready}, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_after_hs_in_ready", {31'b0, in_ready}, 0);
    check_eq("bp_after_hs_valid", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    check_eq("bp_in_ready_rise", {31'b0, in_ready}, 1);
    exp_q.push_back(16'h008F);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_second_taken", {31'b0, in_ready}, 0);
    wait_drain();

    // Reset while the counter is at 5; the pending product must never appear.
    send(8'd11, 8'd13, 16'd143);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outs("rst_mid");
    exp_q.delete();
    acc_q.delete();
    rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    send(8'd7, 8'd9, 16'h003F);
    wait_drain();

    // Back-to-back random operands with both handshakes always ready.
    b2b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      send(rx, ry, exp_prod(rx, ry));
    end
    wait_drain();
    b2b = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
